// File: rtl/seg7_pkg.sv
// Shared glyph table for the 7-segment display path.
// Segment bit i drives segment i+1: bit0 top ... bit5 upper-left, bit6 middle.
package seg7_pkg;

  localparam logic [6:0] GLYPH_0     = 7'b0111111;
  localparam logic [6:0] GLYPH_1     = 7'b0000110;
  localparam logic [6:0] GLYPH_2     = 7'b1011011;
  localparam logic [6:0] GLYPH_3     = 7'b1001111;
  localparam logic [6:0] GLYPH_4     = 7'b1100110;
  localparam logic [6:0] GLYPH_5     = 7'b1101101;
  localparam logic [6:0] GLYPH_6     = 7'b1111101;
  localparam logic [6:0] GLYPH_7     = 7'b0000111;
  localparam logic [6:0] GLYPH_8     = 7'b1111111;
  localparam logic [6:0] GLYPH_9     = 7'b1100111;
  localparam logic [6:0] GLYPH_A     = 7'b1110111;
  localparam logic [6:0] GLYPH_B     = 7'b1111100;
  localparam logic [6:0] GLYPH_C     = 7'b0111001;
  localparam logic [6:0] GLYPH_D     = 7'b1011110;
  localparam logic [6:0] GLYPH_E     = 7'b1111001;
  localparam logic [6:0] GLYPH_F     = 7'b1110001;
  localparam logic [6:0] GLYPH_BLANK = 7'b0000000;

  // Nibbles above 9 only render as letters in hex mode; otherwise they go dark.
  function automatic logic [6:0] glyph(input logic [3:0] nibble, input logic hex_mode);
    logic [6:0] g;
    case (nibble)
      4'h0:    g = GLYPH_0;
      4'h1:    g = GLYPH_1;
      4'h2:    g = GLYPH_2;
      4'h3:    g = GLYPH_3;
      4'h4:    g = GLYPH_4;
      4'h5:    g = GLYPH_5;
      4'h6:    g = GLYPH_6;
      4'h7:    g = GLYPH_7;
      4'h8:    g = GLYPH_8;
      4'h9:    g = GLYPH_9;
      4'hA:    g = hex_mode ? GLYPH_A : GLYPH_BLANK;
      4'hB:    g = hex_mode ? GLYPH_B : GLYPH_BLANK;
      4'hC:    g = hex_mode ? GLYPH_C : GLYPH_BLANK;
      4'hD:    g = hex_mode ? GLYPH_D : GLYPH_BLANK;
      4'hE:    g = hex_mode ? GLYPH_E : GLYPH_BLANK;
      default: g = hex_mode ? GLYPH_F : GLYPH_BLANK;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/seg7_glyph.sv
// Nibble to 7-segment glyph decoder; purely combinational, no backpressure.
// Active-high segments; polarity is applied at the driver's output registers.
module seg7_glyph
  import seg7_pkg::*;
(
  input  logic [3:0] nibble_i,
  input  logic       hex_mode_i,
  output logic [6:0] segments_o
);

  assign segments_o = glyph(nibble_i, hex_mode_i);

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed multi-digit 7-segment driver with frame-synchronous value updates.
// Outputs registered, 1 cycle after scan index/display; load is always accepted.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int DIV_WIDTH  = 10,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load_i,
  input  logic [4*NUM_DIGITS-1:0] value_i,
  input  logic                    hex_mode_i,
  input  logic                    blank_lz_i,
  output logic [6:0]              segments_o,
  output logic [NUM_DIGITS-1:0]   digit_en_o,
  output logic                    frame_done_o
);

  localparam int                    IDX_W    = $clog2(NUM_DIGITS);
  localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(NUM_DIGITS - 1);
  localparam logic [6:0]            SEG_OFF  = {7{ACTIVE_LOW}};
  localparam logic [NUM_DIGITS-1:0] EN_OFF   = {NUM_DIGITS{ACTIVE_LOW}};

  logic [DIV_WIDTH-1:0]    prescaler_q, prescaler_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] pending_q, pending_d;
  logic                    pending_vld_q, pending_vld_d;
  logic [4*NUM_DIGITS-1:0] display_q, display_d;
  logic [6:0]              segments_q, segments_d;
  logic [NUM_DIGITS-1:0]   digit_en_q, digit_en_d;
  logic                    frame_done_q, frame_done_d;

  logic                    tick;
  logic                    boundary;
  logic [3:0]              cur_nibble;
  logic [6:0]              cur_glyph;
  logic [NUM_DIGITS-1:0]   upper_zero;
  logic                    blanked;

  assign tick     = &prescaler_q;
  // Index wraps by explicit compare so non-power-of-2 digit counts scan correctly.
  assign boundary = tick && (idx_q == LAST_IDX);

  always_comb begin
    prescaler_d   = prescaler_q + DIV_WIDTH'(1);
    idx_d         = idx_q;
    pending_d     = pending_q;
    pending_vld_d = pending_vld_q;
    display_d     = display_q;
    if (tick) begin
      idx_d = boundary ? '0 : idx_q + IDX_W'(1);
    end
    if (boundary && pending_vld_q) begin
      display_d     = pending_q;
      pending_vld_d = 1'b0;
    end
    // A load coinciding with the boundary lands in pending and waits a full frame.
    if (load_i) begin
      pending_d     = value_i;
      pending_vld_d = 1'b1;
    end
  end

  assign cur_nibble = display_q[{idx_q, 2'b00} +: 4];

  seg7_glyph u_glyph (
    .nibble_i   (cur_nibble),
    .hex_mode_i (hex_mode_i),
    .segments_o (cur_glyph)
  );

  // upper_zero[k]: every nibble from k up to the most significant is zero.
  always_comb begin
    logic run;
    run        = 1'b1;
    upper_zero = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      run           = run && (display_q[4*k +: 4] == 4'h0);
      upper_zero[k] = run;
    end
  end

  assign blanked = blank_lz_i && (idx_q != '0) && upper_zero[idx_q];

  always_comb begin
    segments_d   = (blanked ? GLYPH_BLANK : cur_glyph) ^ SEG_OFF;
    digit_en_d   = (NUM_DIGITS'(1) << idx_q) ^ EN_OFF;
    frame_done_d = boundary;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescaler_q   <= '0;
      idx_q         <= '0;
      pending_q     <= '0;
      pending_vld_q <= 1'b0;
      display_q     <= '0;
      segments_q    <= SEG_OFF;
      digit_en_q    <= EN_OFF;
      frame_done_q  <= 1'b0;
    end else begin
      prescaler_q   <= prescaler_d;
      idx_q         <= idx_d;
      pending_q     <= pending_d;
      pending_vld_q <= pending_vld_d;
      display_q     <= display_d;
      segments_q    <= segments_d;
      digit_en_q    <= digit_en_d;
      frame_done_q  <= frame_done_d;
    end
  end

  assign segments_o   = segments_q;
  assign digit_en_o   = digit_en_q;
  assign frame_done_o = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver: 4 digits, 4-clock digit period, both polarities.
module tb_seg7_scan_driver;

  logic        clk = 1'b0;
  logic        rst_n, rst_n_al, load, hex_mode, blank_lz;
  logic [15:0] value;
  logic [6:0]  seg, seg_al;
  logic [3:0]  en, en_al;
  logic        fd, fd_al;

  int checks   = 0;
  int failures = 0;

  logic       mon_sel;
  logic [6:0] cap_seg [4];
  logic [3:0] cap_en  [4];

  always #5 clk = ~clk;

  seg7_scan_driver #(.NUM_DIGITS(4), .DIV_WIDTH(2), .ACTIVE_LOW(1'b0)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .load_i       (load),
    .value_i      (value),
    .hex_mode_i   (hex_mode),
    .blank_lz_i   (blank_lz),
    .segments_o   (seg),
    .digit_en_o   (en),
    .frame_done_o (fd)
  );

  seg7_scan_driver #(.NUM_DIGITS(4), .DIV_WIDTH(2), .ACTIVE_LOW(1'b1)) dut_al (
    .clk          (clk),
    .rst_n        (rst_n_al),
    .load_i       (load),
    .value_i      (value),
    .hex_mode_i   (hex_mode),
    .blank_lz_i   (blank_lz),
    .segments_o   (seg_al),
    .digit_en_o   (en_al),
    .frame_done_o (fd_al)
  );

  task automatic do_load(input logic [15:0] v);
    value = v;
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
  endtask

  task automatic wait_fd();
    for (int i = 0; i < 64; i++) begin
      if ((mon_sel ? fd_al : fd) === 1'b1) return;
      @(negedge clk);
    end
    checks++;
    failures++;
    $display("FAIL frame_done_timeout sel=%0d got=0 exp=1", mon_sel);
  endtask

  // Samples the frame that starts right after the next frame_done pulse.
  task automatic capture_frame();
    wait_fd();
    @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) repeat (4) @(negedge clk);
      cap_seg[k] = mon_sel ? seg_al : seg;
      cap_en[k]  = mon_sel ? en_al : en;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rst_n_al = 1'b0; load = 1'b0; value = '0;
    hex_mode = 1'b0; blank_lz = 1'b0; mon_sel = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (seg !== 7'b0000000) begin failures++; $display("FAIL reset_seg got=%b exp=0000000", seg); end
    checks++; if (en !== 4'b0000) begin failures++; $display("FAIL reset_en got=%b exp=0000", en); end
    checks++; if (fd !== 1'b0) begin failures++; $display("FAIL reset_fd got=%b exp=0", fd); end
    checks++; if (seg_al !== 7'b1111111) begin failures++; $display("FAIL reset_seg_al got=%b exp=1111111", seg_al); end
    checks++; if (en_al !== 4'b1111) begin failures++; $display("FAIL reset_en_al got=%b exp=1111", en_al); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (en !== 4'b0001) begin failures++; $display("FAIL release_en got=%b exp=0001", en); end
    checks++; if (seg !== 7'b0111111) begin failures++; $display("FAIL release_seg got=%b exp=0111111", seg); end
  endtask

  task automatic test_scan();
    logic [6:0] exp_seg [4];
    int cnt;
    do_load(16'h1234);
    for (int i = 0; i < 20 && en !== 4'b1000; i++) @(negedge clk);
    checks++; if (en !== 4'b1000) begin failures++; $display("FAIL first_frame_en got=%b exp=1000", en); end
    checks++; if (seg !== 7'b0111111) begin failures++; $display("FAIL first_frame_seg got=%b exp=0111111", seg); end
    capture_frame();
    exp_seg = '{7'b1100110, 7'b1001111, 7'b1011011, 7'b0000110};
    for (int k = 0; k < 4; k++) begin
      checks++; if (cap_seg[k] !== exp_seg[k]) begin failures++; $display("FAIL scan_seg d%0d got=%b exp=%b", k, cap_seg[k], exp_seg[k]); end
      checks++; if (cap_en[k] !== (4'b0001 << k)) begin failures++; $display("FAIL scan_en d%0d got=%b exp=%b", k, cap_en[k], 4'b0001 << k); end
    end
    wait_fd();
    @(negedge clk);
    checks++; if (fd !== 1'b0) begin failures++; $display("FAIL fd_width got=%b exp=0", fd); end
    cnt = 1;
    while (fd !== 1'b1 && cnt < 40) begin
      @(negedge clk);
      cnt++;
    end
    checks++; if (cnt != 16) begin failures++; $display("FAIL fd_period got=%0d exp=16", cnt); end
  endtask

  task automatic test_hex();
    logic [6:0] exp_seg [4];
    hex_mode = 1'b1;
    do_load(16'hAB6F);
    capture_frame();
    exp_seg = '{7'b1110001, 7'b1111101, 7'b1111100, 7'b1110111};
    for (int k = 0; k < 4; k++) begin
      checks++; if (cap_seg[k] !== exp_seg[k]) begin failures++; $display("FAIL hex_seg d%0d got=%b exp=%b", k, cap_seg[k], exp_seg[k]); end
    end
    hex_mode = 1'b0;
    capture_frame();
    exp_seg = '{7'b0000000, 7'b1111101, 7'b0000000, 7'b0000000};
    for (int k = 0; k < 4; k++) begin
      checks++; if (cap_seg[k] !== exp_seg[k]) begin failures++; $display("FAIL dec_seg d%0d got=%b exp=%b", k, cap_seg[k], exp_seg[k]); end
    end
  endtask

  task automatic test_leading_zero();
    logic [6:0] exp_seg [4];
    blank_lz = 1'b1;
    do_load(16'h0070);
    capture_frame();
    exp_seg = '{7'b0111111, 7'b0000111, 7'b0000000, 7'b0000000};
    for (int k = 0; k < 4; k++) begin
      checks++; if (cap_seg[k] !== exp_seg[k]) begin failures++; $display("FAIL lz70_seg d%0d got=%b exp=%b", k, cap_seg[k], exp_seg[k]); end
      checks++; if (cap_en[k] !== (4'b0001 << k)) begin failures++; $display("FAIL lz70_en d%0d got=%b exp=%b", k, cap_en[k], 4'b0001 << k); end
    end
    do_load(16'h0000);
    capture_frame();
    exp_seg = '{7'b0111111, 7'b0000000, 7'b0000000, 7'b0000000};
    for (int k = 0; k < 4; k++) begin
      checks++; if (cap_seg[k] !== exp_seg[k]) begin failures++; $display("FAIL lz00_seg d%0d got=%b exp=%b", k, cap_seg[k], exp_seg[k]); end
    end
    blank_lz = 1'b0;
  endtask

  task automatic test_back_to_back();
    wait_fd();
    repeat (2) @(negedge clk);
    do_load(16'h1111);
    repeat (4) @(negedge clk);
    do_load(16'h2222);
    capture_frame();
    for (int k = 0; k < 4; k++) begin
      checks++; if (cap_seg[k] !== 7'b1011011) begin failures++; $display("FAIL last_wins d%0d got=%b exp=1011011", k, cap_seg[k]); end
    end
    // Second load is held high across the edge that closes the frame.
    wait_fd();
    @(negedge clk);
    do_load(16'h3333);
    repeat (13) @(negedge clk);
    do_load(16'h4444);
    capture_frame();
    for (int k = 0; k < 4; k++) begin
      checks++; if (cap_seg[k] !== 7'b1001111) begin failures++; $display("FAIL boundary_old d%0d got=%b exp=1001111", k, cap_seg[k]); end
    end
    capture_frame();
    for (int k = 0; k < 4; k++) begin
      checks++; if (cap_seg[k] !== 7'b1100110) begin failures++; $display("FAIL boundary_new d%0d got=%b exp=1100110", k, cap_seg[k]); end
    end
  endtask

  task automatic test_async_reset();
    mon_sel  = 1'b1;
    rst_n_al = 1'b1;
    do_load(16'h5555);
    capture_frame();
    for (int k = 0; k < 4; k++) begin
      checks++; if (cap_seg[k] !== 7'b0010010) begin failures++; $display("FAIL al_seg d%0d got=%b exp=0010010", k, cap_seg[k]); end
      checks++; if (cap_en[k] !== ~(4'b0001 << k)) begin failures++; $display("FAIL al_en d%0d got=%b exp=%b", k, cap_en[k], ~(4'b0001 << k)); end
    end
    do_load(16'h6666);
    for (int i = 0; i < 20 && en_al !== 4'b1011; i++) @(negedge clk);
    checks++; if (en_al !== 4'b1011) begin failures++; $display("FAIL al_idx2_en got=%b exp=1011", en_al); end
    #1 rst_n_al = 1'b0;
    #1;
    checks++; if (seg_al !== 7'b1111111) begin failures++; $display("FAIL al_async_seg got=%b exp=1111111", seg_al); end
    checks++; if (en_al !== 4'b1111) begin failures++; $display("FAIL al_async_en got=%b exp=1111", en_al); end
    checks++; if (fd_al !== 1'b0) begin failures++; $display("FAIL al_async_fd got=%b exp=0", fd_al); end
    @(negedge clk);
    rst_n_al = 1'b1;
    @(negedge clk);
    checks++; if (en_al !== 4'b1110) begin failures++; $display("FAIL al_release_en got=%b exp=1110", en_al); end
    checks++; if (seg_al !== 7'b1000000) begin failures++; $display("FAIL al_release_seg got=%b exp=1000000", seg_al); end
    capture_frame();
    for (int k = 0; k < 4; k++) begin
      checks++; if (cap_seg[k] !== 7'b1000000) begin failures++; $display("FAIL al_pending_cleared d%0d got=%b exp=1000000", k, cap_seg[k]); end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_scan();
    test_hex();
    test_leading_zero();
    test_back_to_back();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
